// File: rtl/mult_pkg.sv
// Shared alucontrol codes and FSM state type for the HI/LO multiply/divide unit.
// The div/divu codes are only honoured when MULT_UNIT_DIV_EN is defined.
package mult_pkg;
  localparam logic [4:0] ALU_MULT  = 5'b10011;
  localparam logic [4:0] ALU_MULTU = 5'b10101;
  localparam logic [4:0] ALU_DIV   = 5'b10110;
  localparam logic [4:0] ALU_DIVU  = 5'b10111;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
endpackage

// File: rtl/mult_unit_absneg.sv
// Conditional two's-complement: passes val through, or negates it when neg=1.
module mult_unit_absneg #(
  parameter int W = 32
) (
  input  logic         neg,
  input  logic [W-1:0] val,
  output logic [W-1:0] res
);
  assign res = neg ? -val : val;
endmodule

// File: rtl/mult_unit.sv
// Iterative shift-add multiplier owning HI/LO; one product bit per RUN cycle, sign fixed in FIX.
// Optional restoring divide (div/divu) is built when MULT_UNIT_DIV_EN is defined.
module mult_unit
  import mult_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNTW  = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [4:0]       alucontrol,
  input  logic [WIDTH-1:0] srca,
  input  logic [WIDTH-1:0] srcb,
  input  logic             wehi,
  input  logic             welo,
  input  logic [WIDTH-1:0] wd,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam logic [CNTW-1:0] LAST = CNTW'(WIDTH - 1);

  state_t               state, state_next;
  logic                 supported, op_signed, accept, negate, shift_mplier;
  logic [WIDTH-1:0]     mag_a, mag_b, mcand, mplier;
  logic [2*WIDTH-1:0]   acc, acc_step, prod_fix;
  logic [WIDTH:0]       mul_sum;
  logic [CNTW-1:0]      count;
`ifdef MULT_UNIT_DIV_EN
  logic                 op_div, is_div, rem_neg;
  logic [WIDTH:0]       div_up, div_diff;
  logic [WIDTH-1:0]     quo_fix, rem_fix;
`endif

  always_comb begin
    supported = (alucontrol == ALU_MULT) || (alucontrol == ALU_MULTU);
    op_signed = (alucontrol == ALU_MULT);
`ifdef MULT_UNIT_DIV_EN
    op_div    = (alucontrol == ALU_DIV) || (alucontrol == ALU_DIVU);
    supported = supported || op_div;
    op_signed = op_signed || (alucontrol == ALU_DIV);
`endif
  end

  assign accept = (state == IDLE) && start && supported;

  mult_unit_absneg #(.W(WIDTH)) u_abs_a (
    .neg(op_signed & srca[WIDTH-1]), .val(srca), .res(mag_a));
  mult_unit_absneg #(.W(WIDTH)) u_abs_b (
    .neg(op_signed & srcb[WIDTH-1]), .val(srcb), .res(mag_b));
  mult_unit_absneg #(.W(2*WIDTH)) u_fix_prod (
    .neg(negate), .val(acc), .res(prod_fix));
`ifdef MULT_UNIT_DIV_EN
  mult_unit_absneg #(.W(WIDTH)) u_fix_quo (
    .neg(negate), .val(acc[WIDTH-1:0]), .res(quo_fix));
  mult_unit_absneg #(.W(WIDTH)) u_fix_rem (
    .neg(rem_neg), .val(acc[2*WIDTH-1:WIDTH]), .res(rem_fix));
`endif

  // One iteration: the extra sum bit keeps the add carry inside the accumulator.
  always_comb begin
    mul_sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, mcand & {WIDTH{mplier[0]}}};
    acc_step     = {mul_sum, acc[WIDTH-1:1]};
    shift_mplier = 1'b1;
`ifdef MULT_UNIT_DIV_EN
    div_up   = acc[2*WIDTH-1:WIDTH-1];
    div_diff = div_up - {1'b0, mplier};
    if (is_div) begin
      shift_mplier = 1'b0;
      acc_step = div_diff[WIDTH] ? {div_up[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                 : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (count == LAST) state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN) || (state == FIX);
    done = (state == DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      count  <= '0;
      negate <= 1'b0;
      hi     <= '0;
      lo     <= '0;
`ifdef MULT_UNIT_DIV_EN
      is_div  <= 1'b0;
      rem_neg <= 1'b0;
`endif
    end else begin
      if (accept) begin
        mcand  <= mag_a;
        mplier <= mag_b;
        acc    <= '0;
        count  <= '0;
        negate <= op_signed & (srca[WIDTH-1] ^ srcb[WIDTH-1]);
`ifdef MULT_UNIT_DIV_EN
        is_div  <= op_div;
        rem_neg <= op_signed & srca[WIDTH-1];
        // Divide by zero keeps an all-ones quotient regardless of sign.
        if (op_div) begin
          acc    <= {{WIDTH{1'b0}}, mag_a};
          negate <= op_signed & (srca[WIDTH-1] ^ srcb[WIDTH-1]) & (|srcb);
        end
`endif
      end else if (state == RUN) begin
        acc   <= acc_step;
        count <= count + CNTW'(1);
        if (shift_mplier) mplier <= mplier >> 1;
      end

      if (state == FIX) begin
`ifdef MULT_UNIT_DIV_EN
        if (is_div) begin
          hi <= rem_fix;
          lo <= quo_fix;
        end else begin
          hi <= prod_fix[2*WIDTH-1:WIDTH];
          lo <= prod_fix[WIDTH-1:0];
        end
`else
        hi <= prod_fix[2*WIDTH-1:WIDTH];
        lo <= prod_fix[WIDTH-1:0];
`endif
      end else if ((state == IDLE) || (state == DONE)) begin
        if (wehi) hi <= wd;
        if (welo) lo <= wd;
      end
    end
  end
endmodule

// File: tb/tb_mult_unit.sv
// Self-checking bench for mult_unit: directed edge cases plus random ops against an arithmetic model.
// Div/divu cases are exercised when MULT_UNIT_DIV_EN is defined.
module tb_mult_unit;
  import mult_pkg::*;
  localparam int W = 32;

  logic         clk = 1'b0, reset_n = 1'b0, start = 1'b0, wehi = 1'b0, welo = 1'b0;
  logic [4:0]   alucontrol = '0;
  logic [W-1:0] srca = '0, srcb = '0, wd = '0;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int           checks = 0, fails = 0;
  logic [W-1:0] hi_m = '0, lo_m = '0;

  mult_unit #(.WIDTH(W), .CNTW(6)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .alucontrol(alucontrol),
    .srca(srca), .srcb(srcb), .wehi(wehi), .welo(welo), .wd(wd),
    .busy(busy), .done(done), .hi(hi), .lo(lo));

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [4:0] ctrl, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic wh, input logic wl,
                               input logic [W-1:0] wdata);
    @(negedge clk);
    start = s; alucontrol = ctrl; srca = a; srcb = b; wehi = wh; welo = wl; wd = wdata;
  endtask

  // Arithmetic reference: {hi, lo} straight from 64-bit integer math.
  function automatic logic [63:0] model(input logic [4:0] ctrl, input logic [W-1:0] a,
                                        input logic [W-1:0] b);
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q = 0; r = 0;
    case (ctrl)
      ALU_MULT:  return 64'(sa * sb);
      ALU_MULTU: return {32'b0, a} * {32'b0, b};
`ifdef MULT_UNIT_DIV_EN
      ALU_DIV: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      ALU_DIVU: begin
        if (b == 0) return {a, 32'hFFFFFFFF};
        return {a % b, a / b};
      end
`endif
      default: return {hi_m, lo_m};
    endcase
  endfunction

  // Issues one op; optionally injects start+mthi while busy at cycle 'inject'.
  task automatic run_op(input string tag, input logic [4:0] ctrl, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int inject);
    logic [63:0] exp;
    int          done_at;
    logic        busy_ok, hold_ok;
    exp = model(ctrl, a, b);
    applyStimulus(1'b1, ctrl, a, b, 1'b0, 1'b0, '0);
    done_at = -1; busy_ok = 1'b1; hold_ok = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 100 && done_at < 0; k++) begin
      @(negedge clk);
      if (k == inject) begin
        start = 1'b1; alucontrol = ALU_MULT; srca = $urandom; srcb = $urandom;
        wehi = 1'b1; wd = 32'h1234;
      end else begin
        start = 1'b0; wehi = 1'b0;
      end
      if (done === 1'b1) done_at = k;
      else begin
        if (busy !== 1'b1) busy_ok = 1'b0;
        if (hi !== hi_m || lo !== lo_m) hold_ok = 1'b0;
      end
    end
    checkOutput({tag, " done cycle"}, 64'(done_at), 64'(W + 2));
    checkOutput({tag, " busy while running"}, 64'(busy_ok), 64'd1);
    checkOutput({tag, " hi/lo held"}, 64'(hold_ok), 64'd1);
    checkOutput({tag, " busy at done"}, 64'(busy), 64'd0);
    checkOutput({tag, " result"}, {hi, lo}, exp);
    hi_m = exp[63:32]; lo_m = exp[31:0];
    @(negedge clk);
    checkOutput({tag, " idle after done"}, {62'd0, busy, done}, 64'd0);
  endtask

  initial begin
    logic [4:0]   codes [4];
    logic [W-1:0] ra, rb;
    logic         seen;
    int           nops;
    codes = '{ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU};
`ifdef MULT_UNIT_DIV_EN
    nops = 4;
`else
    nops = 2;
`endif

    repeat (2) @(negedge clk);
    checkOutput("reset state", {busy, done, hi, lo}, 66'd0);
    reset_n = 1'b1;

    run_op("mult 7*-3", ALU_MULT, 32'd7, 32'hFFFFFFFD, 0);
    run_op("multu max*max", ALU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    run_op("mult minint^2", ALU_MULT, 32'h80000000, 32'h80000000, 0);
    run_op("mult ignore midop", ALU_MULT, 32'h00012345, 32'hFFFF0003, 10);

    applyStimulus(1'b0, '0, '0, '0, 1'b0, 1'b1, 32'h1234);
    @(negedge clk);
    welo = 1'b0;
    lo_m = 32'h1234;
    checkOutput("mtlo write", {hi, lo}, {hi_m, lo_m});

    applyStimulus(1'b1, ALU_MULT, $urandom, $urandom, 1'b0, 1'b0, '0);
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    hi_m = '0; lo_m = '0;
    checkOutput("async reset midop", {busy, done, hi, lo}, 66'd0);
    @(negedge clk);
    reset_n = 1'b1;
    run_op("mult 3*4 after reset", ALU_MULT, 32'd3, 32'd4, 0);

    applyStimulus(1'b1, 5'b00010, 32'd9, 32'd9, 1'b0, 1'b0, '0);
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy !== 1'b0 || done !== 1'b0) seen = 1'b1;
    end
    checkOutput("unsupported add ignored", {63'd0, seen}, 64'd0);
    checkOutput("unsupported hi/lo kept", {hi, lo}, {hi_m, lo_m});

`ifdef MULT_UNIT_DIV_EN
    run_op("div -7/2", ALU_DIV, 32'hFFFFFFF9, 32'd2, 0);
    run_op("divu 5/0", ALU_DIVU, 32'd5, 32'd0, 0);
    run_op("div -9/0", ALU_DIV, 32'hFFFFFFF7, 32'd0, 0);
`else
    applyStimulus(1'b1, ALU_DIV, 32'd7, 32'd2, 1'b0, 1'b0, '0);
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy !== 1'b0 || done !== 1'b0) seen = 1'b1;
    end
    checkOutput("div code ignored", {63'd0, seen}, 64'd0);
`endif

    for (int i = 0; i < 10; i++) begin
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 : 32'($urandom);
      if (i == 0) ra = 32'h80000000;
      run_op("random op", codes[$urandom_range(0, nops - 1)], ra, rb, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/mult_unit.md
Name: mult_unit

Overview:
Iterative multi-cycle multiply unit owning the HI/LO register pair. It consumes the 5-bit alucontrol codes produced by the ALU decoder for mult (5'b10011) and multu (5'b10101). It sits beside the ALU in the datapath: the controller pulses start, stalls the pipeline while busy=1, and reads hi/lo for mfhi/mflo. The unit also accepts mthi/mtlo writes.

Parameters:
WIDTH, 32, operand width; hi and lo are each WIDTH bits.
CNTW, 6, iteration counter width; must satisfy 2**CNTW > WIDTH.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset_n  in  1  asynchronous, active-low reset.
start  in  1  request an operation; sampled only in IDLE.
alucontrol  in  5  operation code from the ALU decoder; sampled with start.
srca  in  WIDTH  multiplicand (rs); sampled with start.
srcb  in  WIDTH  multiplier (rt); sampled with start.
wehi  in  1  mthi write enable.
welo  in  1  mtlo write enable.
wd  in  WIDTH  mthi/mtlo write data.
busy  out  1  high from the cycle after accept through the FIX state.
done  out  1  one-cycle pulse; new hi/lo are valid in the same cycle.
hi  out  WIDTH  HI register.
lo  out  WIDTH  LO register.

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0, internal accumulator=0. Reset mid-operation aborts the operation; there is no partial HI/LO update.
- States and transitions:
  - IDLE -> RUN when start=1 and alucontrol is a supported code.
  - RUN -> RUN for WIDTH cycles, then -> FIX.
  - FIX -> DONE.
  - DONE -> IDLE.
- Unsupported code with start=1: ignored, stay in IDLE, no flags.
- Accept (IDLE, start=1):
  - Latch signed flag (1 for mult, 0 for multu).
  - Latch magnitudes |srca| and |srcb| when signed, raw values otherwise.
  - Latch negate flag = signed & (srca[MSB] ^ srcb[MSB]).
  - Clear the 2*WIDTH accumulator; counter=0.
- RUN, each cycle: if multiplier LSB=1, add multiplicand to the upper half of the accumulator with carry. Then shift the accumulator right by 1 and the multiplier right by 1. counter++.
- FIX: if negate=1, result = two's-complement negation of the 2*WIDTH product. hi/lo are written at the end of FIX.
- DONE: done=1 for exactly one cycle and busy=0; hi/lo already show the result.
- Latency: start sampled at edge 0; busy=1 during cycles 1..WIDTH+1; done=1 in cycle WIDTH+2 (34 for WIDTH=32).
- start while busy or in DONE: ignored, not queued.
- hi/lo hold their previous values throughout RUN and FIX.
- mthi/mtlo:
  - wehi/welo write wd into hi/lo at the clock edge, only in IDLE or DONE.
  - Ignored while busy=1.
  - In the same cycle as an accepted start, the write is performed; the product later overwrites it.
- Width edges:
  - 0x80000000 magnitude is 0x80000000 unsigned; signed (-2^31)*(-2^31) gives hi=0x40000000, lo=0.
  - The accumulator carry bit must not be lost: multu 0xFFFFFFFF*0xFFFFFFFF gives hi=0xFFFFFFFE, lo=0x00000001.

Optional Feature:
MULT_UNIT_DIV_EN:
- Defined:
  - Adds codes div (5'b10110) and divu (5'b10111).
  - Restoring division over WIDTH RUN cycles, same latency and handshake as multiply.
  - lo = quotient, hi = remainder.
  - Signed: quotient negated if operand signs differ; remainder takes the dividend's sign.
  - Divide by zero: lo=all-ones, hi=dividend; no exception.
- Undefined: div/divu are unsupported codes and are ignored like any other unsupported code.

Decomposition:
- Package mult_pkg:
  - alucontrol constants ALU_MULT=5'b10011, ALU_MULTU=5'b10101, ALU_DIV=5'b10110, ALU_DIVU=5'b10111.
  - State enum {IDLE, RUN, FIX, DONE}.
- ALU decoder and mult_unit both import the codes from mult_pkg.
- Sub-module mult_unit_absneg: combinational conditional two's-complement, used for operand magnitude and result sign fix.

Test Plan:
- mult: srca=7, srcb=-3 (0xFFFFFFFD), start -> busy cycles 1..33, done in cycle 34, hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- multu: 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. mult: 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
- Mid-operation:
  - start with new operands and wehi=1, wd=0x1234 at cycle 10 -> both ignored, hi/lo unchanged until done.
  - Afterwards in IDLE, welo=1, wd=0x1234 -> lo=0x1234 next cycle.
- reset_n=0 at cycle 15 of a multiply -> immediately busy=0, hi=lo=0, state IDLE; a fresh mult 3*4 then gives lo=12, hi=0.
- start=1, alucontrol=5'b00010 (add) -> busy stays 0, no done, hi/lo unchanged.
- With MULT_UNIT_DIV_EN:
  - div -7/2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
  - divu 5/0 -> lo=0xFFFFFFFF, hi=5.
